// File: rtl/encoder_fec_pkg.sv
// Shared types and codeword bit positions for the extended Hamming(8,4) FEC path.
package encoder_fec_pkg;

    typedef logic [7:0] codeword_t;
    typedef logic [7:0] message_data_t;

    // Bit positions inside an extended Hamming(8,4) codeword
    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D1_POS = 2;
    localparam int P4_POS = 3;
    localparam int D2_POS = 4;
    localparam int D3_POS = 5;
    localparam int D4_POS = 6;
    localparam int P0_POS = 7;

    typedef struct packed {
        logic corr;
        logic uncorr;
    } dec_status_t;

    // Data nibble {d4,d3,d2,d1} taken straight from a codeword
    function automatic logic [3:0] extract_nibble(input codeword_t cw);
        return {cw[D4_POS], cw[D3_POS], cw[D2_POS], cw[D1_POS]};
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational SECDED decode of one extended Hamming(8,4) codeword.
module hamming_syndrome
    import encoder_fec_pkg::*;
(
    input  logic [7:0] cw_i,
    output logic [3:0] nibble_o,
    output logic       corr_o,
    output logic       uncorr_o
);

    logic [2:0] syn;
    logic       pe;
    logic [7:0] flip_mask;
    logic [7:0] fixed_cw;

    // Syndrome, overall parity, and single-bit repair of the codeword
    always_comb begin
        syn[0]    = cw_i[P1_POS] ^ cw_i[D1_POS] ^ cw_i[D2_POS] ^ cw_i[D4_POS];
        syn[1]    = cw_i[P2_POS] ^ cw_i[D1_POS] ^ cw_i[D3_POS] ^ cw_i[D4_POS];
        syn[2]    = cw_i[P4_POS] ^ cw_i[D2_POS] ^ cw_i[D3_POS] ^ cw_i[D4_POS];
        pe        = ^cw_i;
        flip_mask = 8'd0;
        corr_o    = 1'b0;
        uncorr_o  = 1'b0;
        if (pe) begin
            // Odd overall parity: single error. Syndrome 0 means p0 itself flipped,
            // which leaves the data bits untouched.
            corr_o = 1'b1;
            if (syn != 3'd0) begin
                flip_mask = 8'd1 << (syn - 3'd1);
            end
        end else if (syn != 3'd0) begin
            // Even parity with a nonzero syndrome: two errors, raw data passes through
            uncorr_o = 1'b1;
        end
        fixed_cw = cw_i ^ flip_mask;
        nibble_o = extract_nibble(fixed_cw);
    end

endmodule

// File: rtl/hamming_decoder.sv
// SECDED receive decoder: decode stage S1, nibble-pair packer, output register
// and saturating corrected/uncorrectable counters.
module hamming_decoder
    import encoder_fec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             align,
    input  logic             cnt_clr,
    input  logic [7:0]       cw_in,
    input  logic             cw_valid,
    output logic             cw_ready,
    output logic [7:0]       data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_corr,
    output logic             out_uncorr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]    dec_nib;
    logic          dec_corr;
    logic          dec_uncorr;
    dec_status_t   dec_st;

    logic          s1_valid_q, s1_valid_d;
    logic [3:0]    s1_nib_q, s1_nib_d;
    dec_status_t   s1_st_q, s1_st_d;

    logic          half_full_q, half_full_d;
    logic [3:0]    low_nib_q, low_nib_d;
    dec_status_t   low_st_q, low_st_d;

    logic          out_valid_q, out_valid_d;
    message_data_t data_q, data_d;
    logic          out_corr_q, out_corr_d;
    logic          out_uncorr_q, out_uncorr_d;

    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       cnt_hit;

    logic out_load_ok;
    logic s1_adv;
    logic accept;

    hamming_syndrome u_syndrome (
        .cw_i     (cw_in),
        .nibble_o (dec_nib),
        .corr_o   (dec_corr),
        .uncorr_o (dec_uncorr)
    );

    // Handshake and advance conditions for the three-deep pipeline
    always_comb begin
        dec_st      = {dec_corr, dec_uncorr};
        out_load_ok = !out_valid_q || out_ready;
        s1_adv      = s1_valid_q && (!half_full_q || out_load_ok);
        cw_ready    = en && rst_n && (!s1_valid_q || s1_adv);
        accept      = cw_valid && cw_ready;
        cnt_hit     = {s1_st_q.uncorr, s1_st_q.corr} & {2{s1_adv}};
    end

    // Next-state for S1, the pack stage and the output register
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_nib_d     = s1_nib_q;
        s1_st_d      = s1_st_q;
        half_full_d  = half_full_q;
        low_nib_d    = low_nib_q;
        low_st_d     = low_st_q;
        out_valid_d  = out_valid_q;
        data_d       = data_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_nib_d   = dec_nib;
            s1_st_d    = dec_st;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (align) begin
            // Re-alignment drops the held nibble; an advancing nibble starts the new pair
            half_full_d = s1_adv;
            if (s1_adv) begin
                low_nib_d = s1_nib_q;
                low_st_d  = s1_st_q;
            end
        end else if (s1_adv) begin
            if (!half_full_q) begin
                half_full_d = 1'b1;
                low_nib_d   = s1_nib_q;
                low_st_d    = s1_st_q;
            end else begin
                half_full_d  = 1'b0;
                out_valid_d  = 1'b1;
                data_d       = {s1_nib_q, low_nib_q};
                out_corr_d   = s1_st_q.corr | low_st_q.corr;
                out_uncorr_d = s1_st_q.uncorr | low_st_q.uncorr;
            end
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_nib_q     <= 4'd0;
            s1_st_q      <= '0;
            half_full_q  <= 1'b0;
            low_nib_q    <= 4'd0;
            low_st_q     <= '0;
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_nib_q     <= s1_nib_d;
            s1_st_q      <= s1_st_d;
            half_full_q  <= half_full_d;
            low_nib_q    <= low_nib_d;
            low_st_q     <= low_st_d;
            out_valid_q  <= out_valid_d;
            data_q       <= data_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
        end
    end

    // Index 0 counts corrected codewords, index 1 uncorrectable ones
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_cnt
            // Saturating counter; a clear beats a same-cycle increment
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q[gi] <= '0;
                end else if (cnt_clr) begin
                    cnt_q[gi] <= '0;
                end else if (cnt_hit[gi] && (cnt_q[gi] != CNT_MAX)) begin
                    cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign data_out   = data_q;
    assign out_valid  = out_valid_q;
    assign out_corr   = out_corr_q;
    assign out_uncorr = out_uncorr_q;
    assign corr_cnt   = cnt_q[0];
    assign uncorr_cnt = cnt_q[1];

endmodule
